// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_DIV = 1'b0;

  function automatic int unsigned cnt_width(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on a 2W+1 bit partial.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [2*WIDTH:0] partial_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             mul_i,
  output logic [2*WIDTH:0] partial_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] mul_tmp;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   shl_rem;
  logic [WIDTH+1:0] trial;

  always_comb begin
    hi      = partial_i[2*WIDTH:WIDTH];
    sum     = hi + {1'b0, operand_i};
    mul_tmp = {(partial_i[0] ? sum : hi), partial_i[WIDTH-1:0]};

    // Partial remainder never exceeds W bits, so the dropped top bit is always zero.
    shifted = {partial_i[2*WIDTH-1:0], 1'b0};
    shl_rem = shifted[2*WIDTH:WIDTH];
    trial   = {1'b0, shl_rem} - {2'b00, operand_i};

    qbit_o    = 1'b0;
    partial_o = '0;
    if (mul_i == OP_MUL) begin
      partial_o = {1'b0, mul_tmp[2*WIDTH:1]};
    end else begin
      qbit_o    = ~trial[WIDTH+1];
      partial_o = {(qbit_o ? trial[WIDTH:0] : shl_rem), shifted[WIDTH-1:1], qbit_o};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit, fixed WIDTH+1 cycle latency.
// Signed operation is compiled in with `define MULDIV_SIGNED_EN.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               m_d,
  input  logic               sign_in,
  input  logic               start,
  output logic [2*WIDTH:0]   result,
  output logic               ready,
  output logic               busy,
  output logic               div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*WIDTH:0]  part_q;
  logic [2*WIDTH:0]  part_d;
  logic [WIDTH-1:0]  opnd_q;
  logic [WIDTH-1:0]  a_q;
  logic              mul_q;
  logic              b_zero_q;
  logic [2*WIDTH:0]  result_q;
  logic              ready_q;
  logic              busy_q;
  logic              dbz_q;

  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              sgn_fix;
  logic              accept;
  logic [2*WIDTH:0]  fix_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic              unused_qbit;

  assign accept = start & ((state_q == StIdle) | (state_q == StDone));

`ifdef MULDIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic sgn_q;
  logic neg_a_q;
  logic neg_b_q;

  assign neg_a   = sign_in & a_in[WIDTH-1];
  assign neg_b   = sign_in & b_in[WIDTH-1];
  assign mag_a   = neg_a ? (~a_in + 1'b1) : a_in;
  assign mag_b   = neg_b ? (~b_in + 1'b1) : b_in;
  assign sgn_fix = sgn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (accept) begin
      sgn_q   <= sign_in;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = sign_in;
  assign mag_a       = a_in;
  assign mag_b       = b_in;
  assign sgn_fix     = 1'b0;
`endif

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_i(part_q),
    .operand_i(opnd_q),
    .mul_i    (mul_q),
    .partial_o(part_d),
    .qbit_o   (unused_qbit)
  );

  // Signed overflow (most-negative / -1) needs no special case: the magnitude path yields
  // quotient 2^(W-1) and remainder 0, and negating 2^(W-1) leaves the same bit pattern.
  always_comb begin
    prod = part_q[2*WIDTH-1:0];
    quo  = part_q[WIDTH-1:0];
    rem  = part_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    if (neg_a_q ^ neg_b_q) begin
      prod = ~prod + 1'b1;
      quo  = ~quo + 1'b1;
    end
    if (neg_a_q) begin
      rem = ~rem + 1'b1;
    end
`endif
    if (mul_q == OP_MUL) begin
      fix_res = {sgn_fix & prod[2*WIDTH-1], prod};
    end else if (b_zero_q) begin
      fix_res = {sgn_fix & a_q[WIDTH-1], a_q, {WIDTH{1'b1}}};
    end else begin
      fix_res = {sgn_fix & rem[WIDTH-1], rem, quo};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      part_q   <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      mul_q    <= OP_DIV;
      b_zero_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            part_q   <= {{(WIDTH+1){1'b0}}, ((m_d == OP_MUL) ? mag_b : mag_a)};
            opnd_q   <= (m_d == OP_MUL) ? mag_a : mag_b;
            a_q      <= a_in;
            mul_q    <= m_d;
            b_zero_q <= (b_in == '0);
            cnt_q    <= CntW'(WIDTH - 1);
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          part_q <= part_d;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          result_q <= fix_res;
          dbz_q    <= (mul_q == OP_DIV) & b_zero_q;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result      = result_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit, successor to the fixed 64-bit multiply_n_divide_top. It accepts one operation per start, runs a radix-2 shift-add multiply or a restoring divide over WIDTH iterations, and holds the result with a ready flag until the next operation is accepted. Over its predecessor it adds a width parameter, a busy indication, divide-by-zero detection, defined overflow results and optional signed operation. It sits beside the integer ALU as the long-latency arithmetic slave.

## Interface
- WIDTH, 64: operand width, at least 4.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_in  in  WIDTH  multiplicand or dividend.
- b_in  in  WIDTH  multiplier or divisor.
- m_d  in  1  operation select: 1 = multiply, 0 = divide.
- sign_in  in  1  1 = signed two's-complement operation. Ignored (treated as 0) without MULDIV_SIGNED_EN.
- start  in  1  request; sampled only in IDLE or DONE.
- result  out  2*WIDTH+1  multiply: product in [2W-1:0]. Divide: quotient in [W-1:0] and remainder in [2W:W].
- ready  out  1  result valid; held until the next accept.
- busy  out  1  high while an operation is in flight.
- div_by_zero  out  1  divide with b_in==0; valid while ready.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **Accept**
  - In IDLE or DONE with start=1: latch a_in, b_in, m_d, sign_in; clear ready; load iteration counter = WIDTH-1; go to CALC.
  - In DONE with start=0: stay in DONE, hold result.
- **CALC**
  - One iteration per cycle on operand magnitudes (signed mode negates negative operands at accept).
  - Multiply: add multiplicand if the multiplier LSB is set, then shift.
  - Divide: shift partial remainder, trial-subtract the divisor, set the quotient bit.
  - Counter reaching 0 moves to FIX.
- **FIX** (one cycle): apply sign correction and load result, then go to DONE.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - result[2W] sign-extends the remainder or product; it is 0 in unsigned mode.
- **Divide by zero**: quotient = all ones, remainder = dividend (sign-extended to W+1), div_by_zero=1. Latency is unchanged.
- **Signed overflow** (most-negative / -1): quotient = most-negative value, remainder = 0, div_by_zero=0.
- start while in CALC or FIX is ignored; it is not queued.
- Operand inputs may change freely after accept without affecting the operation.

## Timing
- Reset (asynchronous, active-low): state=IDLE, result=0, ready=0, busy=0, div_by_zero=0, counter=0.
- Reset asserted mid-operation aborts immediately; no partial result is exposed.
- Accept at edge 0, with CALC on edges 1..WIDTH.
  - FIX completes at edge WIDTH+1: ready=1, result valid, busy=0.
  - busy=1 from edge 0 up to edge WIDTH+1.
- Total latency is WIDTH+1 cycles and is the same for both operations and all operand values; there is no early termination.
- Back-to-back: start held high in DONE re-accepts on the next edge. ready drops on that edge, so ready is high for exactly one cycle per result.
- result and div_by_zero are registered; they change only at the FIX-to-DONE edge and at reset.

## Configuration
- MULDIV_SIGNED_EN defined:
  - sign_in is honoured.
  - Magnitude conversion at accept and sign correction in FIX are compiled in.
  - Overflow rule applies.
- Not defined:
  - sign_in is ignored and all operations are unsigned.
  - Negation logic is removed; the FIX cycle only loads result, so latency is unchanged.
  - result[2W] is always 0.

## Structure
- Package muldiv_pkg:
  - State enum (IDLE, CALC, FIX, DONE).
  - Op-select constants OP_MUL=1, OP_DIV=0.
  - Localparam helpers for counter width, clog2(WIDTH).
- Sub-module muldiv_step: combinational single-iteration datapath parameterised by WIDTH. It takes partial register, operand and mode, and returns the next partial register plus the quotient bit. The top holds the FSM, counter and registers.

## Test plan
- WIDTH=64, m_d=1, a=3, b=7 → ready after 65 cycles; result=21, div_by_zero=0.
- m_d=0, a=100, b=7 → quotient=14, remainder=2.
- m_d=0, a=5, b=0 → quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, div_by_zero=1.
- MULDIV_SIGNED_EN, sign_in=1:
  - mul a=-6, b=7 → result=-42 sign-extended over 129 bits.
  - div a=-7, b=2 → quotient=-3, remainder=-1.
- start pulsed again at cycle 10 of a busy operation with new operands → ignored; the original result appears at cycle 65 and ready pulses once.
- reset driven low at cycle 30 of a divide → outputs 0 and state IDLE immediately. A subsequent 3×7 completes correctly.
